// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - grid constants, direction/state encodings and cell-index helper for the snake body engine
package snake_pkg;

    localparam int GRID_DIM = 15;
    localparam int MAX_LEN  = GRID_DIM * GRID_DIM;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;
    // Opposing directions differ only in bit 1 of the encoding
    localparam logic [1:0] DIR_REV_XOR = 2'b10;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    localparam logic [3:0] INIT_HEAD_X = 4'd7;
    localparam logic [3:0] INIT_HEAD_Y = 4'd7;
    localparam logic [1:0] INIT_DIR    = DIR_RIGHT;
    localparam logic [7:0] INIT_LEN    = 8'd3;

    // Row-major cell index y*GRID_DIM + x
    function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return ({4'd0, y} * 8'(GRID_DIM)) + {4'd0, x};
    endfunction

endpackage

// File: rtl/snake_seg_fifo.sv
// rtl/snake_seg_fifo.sv - circular {y,x} segment buffer with head push, tail pop and tail read
module snake_seg_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = MAX_LEN
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       init_i,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] tail_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] wr_ptr_q;
    logic [7:0] rd_ptr_q;

    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == 8'(DEPTH - 1)) ? 8'd0 : p + 8'd1;
    endfunction

    // Seed the starting body (tail in slot 0, head in slot 2) or push/pop one segment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= {INIT_HEAD_Y, INIT_HEAD_X - 4'd2};
            mem_q[1] <= {INIT_HEAD_Y, INIT_HEAD_X - 4'd1};
            mem_q[2] <= {INIT_HEAD_Y, INIT_HEAD_X};
            rd_ptr_q <= 8'd0;
            wr_ptr_q <= 8'd3;
        end else if (init_i) begin
            mem_q[0] <= {INIT_HEAD_Y, INIT_HEAD_X - 4'd2};
            mem_q[1] <= {INIT_HEAD_Y, INIT_HEAD_X - 4'd1};
            mem_q[2] <= {INIT_HEAD_Y, INIT_HEAD_X};
            rd_ptr_q <= 8'd0;
            wr_ptr_q <= 8'd3;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // A same-cycle push at full depth overwrites this slot only after it is read
    assign tail_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - snake body store, movement, growth and collision; SNAKE_WRAP_EN makes edges wrap
module snake_body_engine #(
    parameter int GRID_DIM = 15,
    parameter int MAX_LEN  = 225
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Init,
    input  logic       Run,
    input  logic       Tick,
    input  logic [1:0] Dir,
    input  logic [3:0] Food_X,
    input  logic [3:0] Food_Y,
    input  logic [3:0] Query_X,
    input  logic [3:0] Query_Y,
    output logic       Collision,
    output logic [7:0] Length,
    output logic       Ate,
    output logic [3:0] Head_X,
    output logic [3:0] Head_Y,
    output logic       Busy,
    output logic       Cell_Snake
);
    import snake_pkg::*;

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [3:0]         LAST = 4'(GRID_DIM - 1);
    localparam logic [MAX_LEN-1:0] ONE  = MAX_LEN'(1);
    localparam logic [MAX_LEN-1:0] INIT_BITMAP =
        (ONE << cell_idx(INIT_HEAD_X,        INIT_HEAD_Y)) |
        (ONE << cell_idx(INIT_HEAD_X - 4'd1, INIT_HEAD_Y)) |
        (ONE << cell_idx(INIT_HEAD_X - 4'd2, INIT_HEAD_Y));

    state_t             state_q;
    logic [1:0]         dir_q;
    logic [1:0]         dir_lat_q;
    logic [3:0]         cand_x_q;
    logic [3:0]         cand_y_q;
    logic               oob_q;
    logic [3:0]         head_x_q;
    logic [3:0]         head_y_q;
    logic [7:0]         len_q;
    logic               collision_q;
    logic               ate_q;
    logic               busy_q;
    logic [MAX_LEN-1:0] bitmap_q;

    logic [1:0] step_dir;
    logic [3:0] next_x;
    logic [3:0] next_y;
    logic       edge_hit;
    logic [7:0] tail_seg;
    logic [7:0] cand_idx;
    logic [7:0] tail_idx;
    logic [7:0] query_idx;
    logic       grow;
    logic       grow_len;
    logic       hit;
    logic       commit_ok;

    // Resolve the step direction (reverse requests are ignored) and the wrapped candidate head
    always_comb begin
        step_dir = ((dir_lat_q ^ dir_q) == DIR_REV_XOR) ? dir_q : dir_lat_q;
        next_x   = head_x_q;
        next_y   = head_y_q;
        edge_hit = 1'b0;
        case (step_dir)
            DIR_UP: begin
                edge_hit = (head_y_q == 4'd0);
                next_y   = edge_hit ? LAST : head_y_q - 4'd1;
            end
            DIR_RIGHT: begin
                edge_hit = (head_x_q == LAST);
                next_x   = edge_hit ? 4'd0 : head_x_q + 4'd1;
            end
            DIR_DOWN: begin
                edge_hit = (head_y_q == LAST);
                next_y   = edge_hit ? 4'd0 : head_y_q + 4'd1;
            end
            default: begin
                edge_hit = (head_x_q == 4'd0);
                next_x   = edge_hit ? LAST : head_x_q - 4'd1;
            end
        endcase
    end

    assign cand_idx  = cell_idx(cand_x_q, cand_y_q);
    assign tail_idx  = cell_idx(tail_seg[3:0], tail_seg[7:4]);
    assign grow      = (cand_x_q == Food_X) && (cand_y_q == Food_Y);
    assign grow_len  = grow && (len_q < 8'(MAX_LEN));
    // The cell the tail is about to vacate is free, unless this step grows and keeps the tail
    assign hit       = oob_q || (bitmap_q[cand_idx] && !((cand_idx == tail_idx) && !grow));
    assign commit_ok = (state_q == ST_COMMIT) && !hit && !Init;

    snake_seg_fifo #(
        .DEPTH(MAX_LEN)
    ) u_seg_fifo (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .init_i     (Init),
        .push_i     (commit_ok),
        .push_data_i({cand_y_q, cand_x_q}),
        .pop_i      (commit_ok && !grow_len),
        .tail_data_o(tail_seg)
    );

    // Step sequencer: ALIVE waits for a run tick, CALC forms the candidate, COMMIT applies or kills
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_ALIVE;
            dir_q       <= INIT_DIR;
            dir_lat_q   <= INIT_DIR;
            cand_x_q    <= INIT_HEAD_X;
            cand_y_q    <= INIT_HEAD_Y;
            oob_q       <= 1'b0;
            head_x_q    <= INIT_HEAD_X;
            head_y_q    <= INIT_HEAD_Y;
            len_q       <= INIT_LEN;
            collision_q <= 1'b0;
            ate_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else if (Init) begin
            state_q     <= ST_ALIVE;
            dir_q       <= INIT_DIR;
            dir_lat_q   <= INIT_DIR;
            cand_x_q    <= INIT_HEAD_X;
            cand_y_q    <= INIT_HEAD_Y;
            oob_q       <= 1'b0;
            head_x_q    <= INIT_HEAD_X;
            head_y_q    <= INIT_HEAD_Y;
            len_q       <= INIT_LEN;
            collision_q <= 1'b0;
            ate_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ate_q <= 1'b0;
            case (state_q)
                ST_ALIVE: begin
                    if (Tick && Run) begin
                        dir_lat_q <= Dir;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    dir_q    <= step_dir;
                    cand_x_q <= next_x;
                    cand_y_q <= next_y;
                    oob_q    <= edge_hit && !WRAP_EN;
                    state_q  <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    busy_q <= 1'b0;
                    if (hit) begin
                        collision_q <= 1'b1;
                        state_q     <= ST_DEAD;
                    end else begin
                        head_x_q <= cand_x_q;
                        head_y_q <= cand_y_q;
                        if (grow_len) begin
                            len_q <= len_q + 8'd1;
                            ate_q <= 1'b1;
                        end
                        state_q <= ST_ALIVE;
                    end
                end
                default: begin
                    state_q <= ST_DEAD;
                end
            endcase
        end
    end

    // Occupancy: full-width restore, else mark the new head and free the tail on a non-growing move
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bitmap_q <= INIT_BITMAP;
        end else if (Init) begin
            bitmap_q <= INIT_BITMAP;
        end else if (commit_ok) begin
            if (!grow_len) begin
                bitmap_q[tail_idx] <= 1'b0;
            end
            bitmap_q[cand_idx] <= 1'b1;
        end
    end

    assign query_idx  = cell_idx(Query_X, Query_Y);
    assign Cell_Snake = (Query_X <= LAST) && (Query_Y <= LAST) && bitmap_q[query_idx];

    assign Collision = collision_q;
    assign Length    = len_q;
    assign Ate       = ate_q;
    assign Head_X    = head_x_q;
    assign Head_Y    = head_y_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// tb/tb_snake_body_engine.sv - directed and random checks of snake_body_engine against a queue-based body model
module tb_snake_body_engine;

    logic       Clk = 1'b0;
    logic       Reset, Init, Run, Tick;
    logic [1:0] Dir;
    logic [3:0] Food_X, Food_Y, Query_X, Query_Y;
    logic       Collision, Ate, Busy, Cell_Snake;
    logic [7:0] Length;
    logic [3:0] Head_X, Head_Y;

    int checks   = 0;
    int failures = 0;

    // Body model: element 0 is the head, entries are {y,x}
    logic [7:0] body[$];
    logic [1:0] m_dir;
    bit         m_dead;
    int         m_fx, m_fy;

    snake_body_engine #(.GRID_DIM(15), .MAX_LEN(225)) dut (
        .Clk(Clk), .Reset(Reset), .Init(Init), .Run(Run), .Tick(Tick), .Dir(Dir),
        .Food_X(Food_X), .Food_Y(Food_Y), .Query_X(Query_X), .Query_Y(Query_Y),
        .Collision(Collision), .Length(Length), .Ate(Ate), .Head_X(Head_X),
        .Head_Y(Head_Y), .Busy(Busy), .Cell_Snake(Cell_Snake)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        body = {};
        body.push_back({4'd7, 4'd7});
        body.push_back({4'd7, 4'd6});
        body.push_back({4'd7, 4'd5});
        m_dir  = 2'b01;
        m_dead = 1'b0;
    endtask

    function automatic bit model_occ(input int x, input int y);
        if (x > 14 || y > 14) return 1'b0;
        foreach (body[i]) if (body[i] == {4'(y), 4'(x)}) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic [1:0] req, output bit ate);
        logic [7:0] h;
        int  nx, ny;
        bit  out, hit, grow;
        ate = 1'b0;
        if (!m_dead) begin
            if ((req ^ m_dir) != 2'b10) m_dir = req;
            h  = body[0];
            nx = int'(h[3:0]);
            ny = int'(h[7:4]);
            case (m_dir)
                2'b00:   ny = ny - 1;
                2'b01:   nx = nx + 1;
                2'b10:   ny = ny + 1;
                default: nx = nx - 1;
            endcase
            out = (nx < 0) || (nx > 14) || (ny < 0) || (ny > 14);
`ifdef SNAKE_WRAP_EN
            nx  = (nx + 15) % 15;
            ny  = (ny + 15) % 15;
            out = 1'b0;
`endif
            grow = (nx == m_fx) && (ny == m_fy);
            hit  = out;
            if (!out) begin
                for (int i = 0; i < body.size(); i++) begin
                    if (!(i == body.size() - 1 && !grow) && body[i] == {4'(ny), 4'(nx)}) hit = 1'b1;
                end
            end
            if (hit) begin
                m_dead = 1'b1;
            end else begin
                body.push_front({4'(ny), 4'(nx)});
                if (grow && body.size() <= 225) ate = 1'b1;
                else void'(body.pop_back());
            end
        end
    endtask

    task automatic query(input int x, input int y, input string tag);
        Query_X = 4'(x);
        Query_Y = 4'(y);
        #1;
        chk(tag, Cell_Snake, model_occ(x, y));
    endtask

    task automatic check_state(input string tag);
        logic [7:0] h;
        h = body[0];
        chk({tag, ".head_x"}, Head_X, h[3:0]);
        chk({tag, ".head_y"}, Head_Y, h[7:4]);
        chk({tag, ".length"}, Length, body.size());
        chk({tag, ".collision"}, Collision, m_dead);
        query($urandom_range(0, 15), $urandom_range(0, 15), {tag, ".q0"});
        query($urandom_range(0, 15), $urandom_range(0, 15), {tag, ".q1"});
    endtask

    // Called at a negative edge; leaves the bench at a negative edge
    task automatic do_step(input logic [1:0] d, input int fx, input int fy, input string tag);
        bit ate;
        Dir    = d;
        Food_X = 4'(fx);
        Food_Y = 4'(fy);
        m_fx   = fx;
        m_fy   = fy;
        Tick   = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Tick = 1'b0;
        chk({tag, ".busy"}, Busy, !m_dead);
        model_step(d, ate);
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        chk({tag, ".ate"}, Ate, ate);
        check_state(tag);
        @(negedge Clk);
        chk({tag, ".ate_clr"}, Ate, 1'b0);
    endtask

    task automatic pulse_init();
        Init = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Init = 1'b0;
        model_init();
    endtask

    initial begin
        logic [7:0] h;
        int fx, fy, ax, ay;
        logic [1:0] rd;

        Reset = 1'b1; Init = 1'b0; Run = 1'b0; Tick = 1'b0; Dir = 2'b01;
        Food_X = 4'd0; Food_Y = 4'd0; Query_X = 4'd0; Query_Y = 4'd0;
        model_init();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Reset state
        query(5, 7, "rst.q57");
        chk("rst.q57_const", Cell_Snake, 1'b1);
        query(7, 7, "rst.q77");
        chk("rst.q77_const", Cell_Snake, 1'b1);
        query(8, 7, "rst.q87");
        chk("rst.q87_const", Cell_Snake, 1'b0);
        query(15, 7, "rst.qx15");
        query(7, 15, "rst.qy15");
        chk("rst.length", Length, 8'd3);
        chk("rst.head_x", Head_X, 4'd7);
        chk("rst.head_y", Head_Y, 4'd7);
        chk("rst.collision", Collision, 1'b0);
        chk("rst.busy", Busy, 1'b0);
        chk("rst.ate", Ate, 1'b0);

        // Tick with Run low is ignored
        Tick = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Tick = 1'b0;
        chk("norun.busy", Busy, 1'b0);
        repeat (2) @(negedge Clk);
        check_state("norun");

        // Growing step right onto food
        Run = 1'b1;
        do_step(2'b01, 8, 7, "grow");
        chk("grow.head_const", Head_X, 4'd8);
        chk("grow.len_const", Length, 8'd4);
        query(5, 7, "grow.q57");

        // Reverse request keeps heading right
        pulse_init();
        do_step(2'b11, 0, 0, "rev");
        chk("rev.head_const", Head_X, 4'd8);

        // Run to the right edge, then step off it
        for (int i = 0; i < 6; i++) do_step(2'b01, 0, 0, "right");
        chk("edge.head_const", Head_X, 4'd14);
        do_step(2'b01, 0, 0, "exit");
`ifdef SNAKE_WRAP_EN
        chk("exit.head_const", Head_X, 4'd0);
        chk("exit.coll_const", Collision, 1'b0);
`else
        chk("exit.head_const", Head_X, 4'd14);
        chk("exit.coll_const", Collision, 1'b1);
`endif
        do_step(2'b10, 0, 0, "dead");

        // 2x2 square onto the tail cell: legal without food, fatal with food there
        pulse_init();
        do_step(2'b01, 8, 7, "sq.a");
        do_step(2'b10, 0, 0, "sq.b");
        do_step(2'b11, 0, 0, "sq.c");
        do_step(2'b00, 0, 0, "sq.d");
        chk("sq.coll_const", Collision, 1'b0);
        pulse_init();
        do_step(2'b01, 8, 7, "sqf.a");
        do_step(2'b10, 0, 0, "sqf.b");
        do_step(2'b11, 0, 0, "sqf.c");
        do_step(2'b00, 7, 7, "sqf.d");
        chk("sqf.coll_const", Collision, 1'b1);

        // Asynchronous reset between edges
        #2;
        Reset = 1'b1;
        #1;
        model_init();
        chk("areset.collision", Collision, 1'b0);
        chk("areset.length", Length, 8'd3);
        chk("areset.busy", Busy, 1'b0);
        check_state("areset");
        @(negedge Clk);
        Reset = 1'b0;

        // Init during COMMIT of a growing step aborts it
        Dir = 2'b01; Food_X = 4'd8; Food_Y = 4'd7; Tick = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Tick = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Init = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Init = 1'b0;
        model_init();
        chk("abort.ate", Ate, 1'b0);
        chk("abort.length", Length, 8'd3);
        chk("abort.busy", Busy, 1'b0);
        query(8, 7, "abort.q87");
        query(5, 7, "abort.q57");
        check_state("abort");
        repeat (3) @(negedge Clk);
        check_state("abort.hold");

        // Tick held through the busy cycles yields a single step
        Dir = 2'b01; Food_X = 4'd0; Food_Y = 4'd0; m_fx = 0; m_fy = 0; Tick = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Tick = 1'b0;
        begin
            bit a;
            model_step(2'b01, a);
        end
        repeat (4) @(negedge Clk);
        chk("busydrop.head_const", Head_X, 4'd8);
        chk("busydrop.busy", Busy, 1'b0);
        check_state("busydrop");

        // Random walk with food often placed just ahead
        pulse_init();
        for (int n = 0; n < 150; n++) begin
            rd = 2'($urandom_range(0, 3));
            h  = body[0];
            ax = int'(h[3:0]) + ((rd == 2'b01) ? 1 : (rd == 2'b11) ? -1 : 0);
            ay = int'(h[7:4]) + ((rd == 2'b10) ? 1 : (rd == 2'b00) ? -1 : 0);
            if ($urandom_range(0, 1) == 1 && ax >= 0 && ax <= 14 && ay >= 0 && ay <= 14) begin
                fx = ax;
                fy = ay;
            end else begin
                fx = $urandom_range(0, 14);
                fy = $urandom_range(0, 14);
            end
            do_step(rd, fx, fy, "rnd");
            if (m_dead) begin
                pulse_init();
                check_state("rnd.init");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
